// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // The divide state is MD_DIV_ST because MD_DIV already names the op encoding.
   typedef enum logic [1:0] {
      MD_IDLE   = 2'd0,
      MD_MUL    = 2'd1,
      MD_DIV_ST = 2'd2,
      MD_FIX    = 2'd3
   } md_state_e;

   localparam int          MD_ITERS   = 32;
   localparam logic [31:0] MD_DZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring-divide step: shift in the next dividend bit, trial-subtract the divisor.
module md_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] div_i,
   input  logic         bit_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);

   logic [W:0] shifted;
   logic [W:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, div_i};
   // A clear top bit means the trial subtraction did not borrow.
   assign q_o     = ~diff[W];
   assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO/MFHI/MFLO access.
// Optional MD_EARLY_TERM_EN: multiply stops once the remaining multiplier magnitude is zero.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int MD_W = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            md_start,
   input  logic [1:0]      md_op,
   input  logic [MD_W-1:0] src_a,
   input  logic [MD_W-1:0] src_b,
   input  logic [1:0]      hilo_wr,
   input  logic            hilo_sel,
   output logic            md_run,
   output logic [MD_W-1:0] hilo_out
);

   localparam int AW = 2 * MD_W;

   function automatic logic [MD_W-1:0] cneg(input logic [MD_W-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   md_state_e       state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [MD_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [AW-1:0]   acc_q, acc_d, mcand_q, mcand_d;
   logic [MD_W-1:0] opb_q, opb_d, srca_q, srca_d;
   logic            neg_q, neg_d, rneg_q, rneg_d, isdiv_q, isdiv_d, dz_q, dz_d;

   logic            is_div, signed_op, a_neg, b_neg;
   logic [MD_W-1:0] a_mag, b_mag, step_rem;
   logic            step_q;
   logic [AW-1:0]   prod;

   assign is_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
   assign signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
   assign a_neg     = signed_op & src_a[MD_W-1];
   assign b_neg     = signed_op & src_b[MD_W-1];
   assign a_mag     = cneg(src_a, a_neg);
   assign b_mag     = cneg(src_b, b_neg);
   assign prod      = neg_q ? -acc_q : acc_q;

   // During divide acc holds {partial remainder, dividend/quotient shift register}.
   md_div_step #(.W(MD_W)) u_step (
      .rem_i (acc_q[AW-1:MD_W]),
      .div_i (opb_q),
      .bit_i (acc_q[MD_W-1]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
      srca_q  <= srca_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      isdiv_q <= isdiv_d;
      dz_q    <= dz_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         MD_IDLE: begin
            if (md_start) begin
               cnt_d   = 6'(MD_ITERS);
               state_d = is_div ? MD_DIV_ST : MD_MUL;
`ifdef MD_EARLY_TERM_EN
               if (!is_div && (b_mag == '0)) state_d = MD_FIX;
`endif
            end
         end
         MD_MUL: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = MD_FIX;
`ifdef MD_EARLY_TERM_EN
            if (opb_q[MD_W-1:1] == '0) state_d = MD_FIX;
`endif
         end
         MD_DIV_ST: begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = MD_FIX;
         end
         MD_FIX: begin
            cnt_d   = '0;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      md_run   = (state_q != MD_IDLE);
      hilo_out = hilo_sel ? hi_q : lo_q;
   end

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      opb_d   = opb_q;
      srca_d  = srca_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      isdiv_d = isdiv_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (md_start) begin
               acc_d   = is_div ? {{MD_W{1'b0}}, a_mag} : '0;
               mcand_d = {{MD_W{1'b0}}, a_mag};
               opb_d   = b_mag;
               srca_d  = src_a;
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               isdiv_d = is_div;
               dz_d    = (src_b == '0);
            end else begin
               if (hilo_wr[1]) hi_d = src_a;
               if (hilo_wr[0]) lo_d = src_a;
            end
         end
         MD_MUL: begin
            if (opb_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
         end
         MD_DIV_ST: acc_d = {step_rem, acc_q[MD_W-2:0], step_q};
         MD_FIX: begin
            if (!isdiv_q) begin
               hi_d = prod[AW-1:MD_W];
               lo_d = prod[MD_W-1:0];
            end else if (dz_q) begin
               hi_d = srca_q;
               lo_d = MD_W'(MD_DZ_QUOT);
            end else begin
               hi_d = cneg(acc_q[AW-1:MD_W], rneg_q);
               lo_d = cneg(acc_q[MD_W-1:0], neg_q);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: products, quotients, divide-by-zero, HI/LO access, reset abort.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_start;
   logic [1:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [1:0]  hilo_wr;
   logic        hilo_sel;
   logic        md_run;
   logic [31:0] hilo_out;

   int total = 0;
   int bad   = 0;

`ifdef MD_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   always #5 clk = ~clk;

   mult_div_unit #(.MD_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .md_start (md_start),
      .md_op    (md_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .hilo_wr  (hilo_wr),
      .hilo_sel (hilo_sel),
      .md_run   (md_run),
      .hilo_out (hilo_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hilo(input string tag, input logic [31:0] want_hi, input logic [31:0] want_lo);
      hilo_sel = 1'b1;
      #1;
      chk({tag, ".hi"}, hilo_out, want_hi);
      hilo_sel = 1'b0;
      #1;
      chk({tag, ".lo"}, hilo_out, want_lo);
   endtask

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
      logic [31:0] m;
      int k;
      m = (op == 2'b00 && b[31]) ? -b : b;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      if (EARLY && !op[1]) return k + 1;
      return 33;
   endfunction

   task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      md_op    = op;
      src_a    = a;
      src_b    = b;
      md_start = 1'b1;
      step();
      md_start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (md_run === 1'b1 && n < 100) begin
         n++;
         step();
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want_hi, input logic [31:0] want_lo);
      int n;
      start(op, a, b);
      wait_done(n);
      chk({tag, ".lat"}, n, exp_lat(op, b));
      chk_hilo(tag, want_hi, want_lo);
   endtask

   initial begin
      int n;
      reset    = 1'b0;
      md_start = 1'b0;
      md_op    = 2'b00;
      src_a    = '0;
      src_b    = '0;
      hilo_wr  = 2'b00;
      hilo_sel = 1'b0;
      step();
      step();
      chk("rst.run", {31'b0, md_run}, 32'd0);
      chk_hilo("rst", 32'h0, 32'h0);
      reset = 1'b1;
      step();

      run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("div_dz", 2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);
      run_op("divu_dz", 2'b11, 32'd5, 32'h0, 32'd5, 32'hFFFF_FFFF);

      // MTHI/MTLO attempted while an operation is running
      start(2'b11, 32'd1000, 32'd10);
      step();
      step();
      hilo_wr = 2'b11;
      src_a   = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) step();
      chk_hilo("wr_run", 32'd5, 32'hFFFF_FFFF);
      hilo_wr = 2'b00;
      wait_done(n);
      chk_hilo("wr_run_end", 32'h0, 32'd100);

      hilo_wr = 2'b10;
      src_a   = 32'h0000_ABCD;
      step();
      hilo_wr = 2'b00;
      chk_hilo("mthi", 32'h0000_ABCD, 32'd100);
      hilo_wr = 2'b01;
      src_a   = 32'h0000_1234;
      step();
      hilo_wr = 2'b00;
      chk_hilo("mtlo", 32'h0000_ABCD, 32'h0000_1234);
      hilo_wr = 2'b11;
      src_a   = 32'h0000_55AA;
      step();
      hilo_wr = 2'b00;
      chk_hilo("mtboth", 32'h0000_55AA, 32'h0000_55AA);

      // start and write in the same cycle: start wins
      md_op    = 2'b01;
      src_a    = 32'd6;
      src_b    = 32'd7;
      hilo_wr  = 2'b11;
      md_start = 1'b1;
      step();
      md_start = 1'b0;
      hilo_wr  = 2'b00;
      chk("sw.run", {31'b0, md_run}, 32'd1);
      chk_hilo("sw.during", 32'h0000_55AA, 32'h0000_55AA);
      wait_done(n);
      chk_hilo("sw.end", 32'h0, 32'd42);

      // reset in the middle of a divide
      hilo_wr = 2'b11;
      src_a   = 32'h0000_CAFE;
      step();
      hilo_wr = 2'b00;
      chk_hilo("pre_rst", 32'h0000_CAFE, 32'h0000_CAFE);
      start(2'b10, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) step();
      chk("mid.run", {31'b0, md_run}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst.run", {31'b0, md_run}, 32'd0);
      chk_hilo("mid_rst", 32'h0, 32'h0);
      step();
      reset = 1'b1;
      step();
      chk("post_rst.run", {31'b0, md_run}, 32'd0);
      chk_hilo("post_rst", 32'h0, 32'h0);

      run_op("multu_small", 2'b01, 32'd5, 32'd3, 32'h0, 32'd15);
      run_op("multu_zero", 2'b01, 32'd9, 32'd0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
